// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared constants and helpers for the SPI memory engine.
//   - SPI command opcodes
//   - FSM state encodings (IDLE / SHIFT / FINISH / DONE)
//   - xfer_len(): maps a request byte count to a total SPI bit count plus a legal flag
package spi_mem_pkg;

    localparam logic [7:0] SPI_READ_CMD  = 8'h03;
    localparam logic [7:0] SPI_WRITE_CMD = 8'h02;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SHIFT  = 2'd1;
    localparam state_t ST_FINISH = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    typedef struct packed {
        logic       legal;
        logic [6:0] bits;   // 8-bit command + 24-bit address + 8*num_bytes data
    } xfer_len_t;

    function automatic xfer_len_t xfer_len(input logic [2:0] num_bytes);
        xfer_len_t r;
        r.legal = 1'b1;
        r.bits  = 7'd0;
        case (num_bytes)
            3'd1:    r.bits = 7'd40;
            3'd2:    r.bits = 7'd48;
            3'd4:    r.bits = 7'd64;
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/spi_mem_engine_shifter.sv
// spi_shifter: SPI mode-0 bit engine.
//   Serializes a 64-bit frame MSB first on mosi and deserializes miso into a
//   32-bit word. Each bit is two clocks: phase 0 (sclk low, mosi valid) and
//   phase 1 (sclk high). miso is sampled on the edge that raises sclk, but only
//   for bits past the 32-bit command/address header.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   load             start a frame (load_data, load_bits sampled)
//   load_data[63:0]  frame, left-justified
//   load_bits[6:0]   number of bits to send (>= 32)
//   miso             serial data in
//   sclk, mosi       registered SPI clock / data out
//   rx_data[31:0]    received word (cleared on load)
//   busy             frame in progress
//   last_bit         high during the final phase-1 clock of the frame
module spi_shifter
    import spi_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] load_data,
    input  logic [6:0]  load_bits,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic [31:0] rx_data,
    output logic        busy,
    output logic        last_bit
);

    logic [63:0] sreg;
    logic [6:0]  count;      // bits remaining, including the current one
    logic [6:0]  data_bits;  // bits remaining once the header is out
    logic        phase;
    logic        busy_q;

    assign busy     = busy_q;
    assign last_bit = busy_q & phase & (count == 7'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg      <= '0;
            count     <= '0;
            data_bits <= '0;
            phase     <= 1'b0;
            busy_q    <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            rx_data   <= '0;
        end else if (load) begin
            sreg      <= load_data;
            count     <= load_bits;
            data_bits <= load_bits - 7'd32;
            phase     <= 1'b0;
            busy_q    <= 1'b1;
            sclk      <= 1'b0;
            mosi      <= load_data[63];
            rx_data   <= '0;
        end else if (busy_q) begin
            if (!phase) begin
                phase <= 1'b1;
                sclk  <= 1'b1;
                // count <= data_bits means bit index >= 32: header already sent
                if (count <= data_bits)
                    rx_data <= {rx_data[30:0], miso};
            end else begin
                phase <= 1'b0;
                sclk  <= 1'b0;
                sreg  <= {sreg[62:0], 1'b0};
                count <= count - 7'd1;
                if (count == 7'd1) begin
                    busy_q <= 1'b0;
                    mosi   <= 1'b0;     // line parks low once the frame ends
                end else begin
                    mosi   <= sreg[62];
                end
            end
        end
    end

endmodule

// File: rtl/spi_mem_engine.sv
// spi_mem_engine: turns one CPU memory request into an SPI read/write of
// 1, 2 or 4 bytes on flash (cs1) or RAM (cs2).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start_request          level request, held until request_done
//   is_write, num_bytes,
//   target_address,
//   write_value            request fields, sampled when the request is accepted
//   fetched_value[31:0]    read data; first byte received lands in the top used byte
//   request_done           completion flag, held until start_request drops
//   sclk, mosi, miso       SPI bus (mode 0)
//   cs1, cs2               flash / RAM chip selects, active low
module spi_mem_engine
    import spi_mem_pkg::*;
#(
    parameter int         ADDRESS_SIZE = 18,
    parameter logic [7:0] READ_CMD     = SPI_READ_CMD,
    parameter logic [7:0] WRITE_CMD    = SPI_WRITE_CMD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_request,
    input  logic                    is_write,
    input  logic [2:0]              num_bytes,
    input  logic [ADDRESS_SIZE-1:0] target_address,
    input  logic [31:0]             write_value,
    output logic [31:0]             fetched_value,
    output logic                    request_done,
    output logic                    sclk,
    output logic                    mosi,
    input  logic                    miso,
    output logic                    cs1,
    output logic                    cs2
);

    state_t      state;
    xfer_len_t   len;
    logic [23:0] addr24;
    logic [31:0] tx_data;
    logic [63:0] frame;
    logic        load;
    logic        busy;
    logic        last_bit;

    always_comb begin
        addr24 = '0;
        addr24[ADDRESS_SIZE-2:0] = target_address[ADDRESS_SIZE-2:0];
    end

    // Store data goes out byte 0 first; reads shift zeros in the data slot.
    assign tx_data = is_write ? {write_value[7:0], write_value[15:8],
                                 write_value[23:16], write_value[31:24]} : 32'h0;
    assign frame   = {(is_write ? WRITE_CMD : READ_CMD), addr24, tx_data};
    assign len     = xfer_len(num_bytes);
    assign load    = (state == ST_IDLE) && start_request && len.legal;

    spi_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (frame),
        .load_bits (len.bits),
        .miso      (miso),
        .sclk      (sclk),
        .mosi      (mosi),
        .rx_data   (fetched_value),
        .busy      (busy),
        .last_bit  (last_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cs1          <= 1'b1;
            cs2          <= 1'b1;
            request_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_request) begin
                        if (len.legal) begin
                            state <= ST_SHIFT;
                            cs1   <= target_address[ADDRESS_SIZE-1];
                            cs2   <= ~target_address[ADDRESS_SIZE-1];
                        end else begin
                            // Illegal length: no bus activity; request_done
                            // follows from DONE on the next edge.
                            state <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    // !busy only as a recovery guard; last_bit is the normal exit.
                    if (last_bit || !busy) begin
                        state <= ST_FINISH;
                        cs1   <= 1'b1;
                        cs2   <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    state        <= ST_DONE;
                    request_done <= 1'b1;
                end
                default: begin  // ST_DONE
                    if (!start_request) begin
                        state        <= ST_IDLE;
                        request_done <= 1'b0;
                    end else begin
                        request_done <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/spi_mem_engine.md
Name: spi_mem_engine

Overview:
- SPI master transaction engine that turns one CPU memory request into a serial flash or RAM access and returns the assembled word.
- Sits directly downstream of the CPU core's memory request interface, inside the memory bus, and drives sclk, mosi and the two chip selects.
- Serves both instruction fetch and load/store traffic.
- The top address bit selects the chip: cs1 is flash, cs2 is RAM.

Parameters:
- ADDRESS_SIZE, 18, request address width; bit ADDRESS_SIZE-1 is the chip select bit, bits ADDRESS_SIZE-2:0 are the byte address.
- READ_CMD, 8'h03, SPI read opcode.
- WRITE_CMD, 8'h02, SPI write opcode.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start_request  input  1  level request from the CPU; held high until request_done is seen.
- is_write  input  1  1 = write write_value, 0 = read; sampled at start.
- num_bytes  input  3  transfer length in bytes (1, 2 or 4); sampled at start.
- target_address  input  ADDRESS_SIZE  byte address plus chip select bit; sampled at start.
- write_value  input  32  store data, little-endian; sampled at start.
- fetched_value  output  32  read data.
- request_done  output  1  transaction-complete flag.
- sclk  output  1  SPI clock, mode 0.
- mosi  output  1  SPI data out.
- miso  input  1  SPI data in.
- cs1  output  1  flash chip select, active low.
- cs2  output  1  RAM chip select, active low.

Behaviour:
- Reset values (checked every clock edge with rst=1, including mid-transaction):
  - state IDLE; cs1=cs2=1; sclk=0; mosi=0; request_done=0; fetched_value=0.
  - Any transfer in progress is abandoned.
- All outputs are registered.
- States: IDLE, SHIFT, FINISH, DONE.
- IDLE, on start_request=1 at edge k:
  - Latch the inputs.
  - Set the bit count B = 32 + 8*num_bytes.
  - Load the 64-bit shift register, MSB first: cmd, then 24-bit address {zero-padded, target_address[ADDRESS_SIZE-2:0]}, then data. Data is write_value[7:0], [15:8], [23:16], [31:24], or zeros for a read.
  - Drive cs1 low if target_address[ADDRESS_SIZE-1]=0, otherwise cs2 low.
  - Clear fetched_value.
  - Go to SHIFT with phase=0.
- Illegal num_bytes (0, 3, 5-7):
  - No chip select asserted; go straight to DONE; fetched_value is left unchanged.
- SHIFT: each bit takes 2 clocks.
  - Phase 0: sclk=0; mosi = shift-register MSB.
  - Phase 1: sclk=1; on that edge miso is sampled.
  - Sampling only happens once the bit index is at least 32, i.e. the command and address bits have gone out. Sampled data shifts in as fetched_value = {fetched_value[30:0], miso}.
  - At the end of phase 1, shift the register left and decrement the count.
  - When the count reaches 0, go to FINISH.
  - SHIFT lasts exactly 2*B clocks.
- Read data placement:
  - The first received byte ends up in the most significant used byte: bits [31:24] for 4 bytes, [15:8] for 2 bytes, [7:0] for 1 byte.
  - The CPU does the byte swap and sign extension.
- FINISH: one clock; cs1=cs2=1, sclk=0, mosi=0; then go to DONE.
- DONE:
  - request_done=1.
  - Stay in DONE while start_request=1.
  - When start_request=0, go to IDLE and drop request_done on the same edge.
- Latency: request_done is high after 2*B+2 edges counted from edge k. That is 130 edges for 4 bytes, 98 for 2, 82 for 1, and 2 for illegal lengths.
- A start_request dropped mid-transfer is ignored; the transfer completes, and DONE lasts one cycle.
- start_request must be low for at least one cycle between requests, because DONE only returns to IDLE on start_request=0.
- Inputs changing after edge k have no effect.
- fetched_value stays stable from DONE until the next start.

Decomposition:
- Shared package spi_mem_pkg holds:
  - the READ_CMD and WRITE_CMD values;
  - the state enum (IDLE/SHIFT/FINISH/DONE);
  - the function that maps num_bytes to a bit count and a legal flag.
- One natural sub-module, spi_shifter: the 64-bit serializer plus the 32-bit deserializer, the phase toggle and the bit counter, with load/busy/last-bit handshake. The FSM and chip-select decode stay in spi_mem_engine.

Test Plan:
- 4-byte flash read: address 0x00010, miso model returns bytes 0x13,0x05,0x00,0x00.
  - cs1 low and cs2 high throughout.
  - mosi carries 0x03,0x00,0x00,0x10.
  - fetched_value = 0x13050000.
  - request_done rises at edge 130.
- 1-byte RAM write: target_address bit17=1, addr 0x00044, write_value 0x000000A5.
  - cs2 low.
  - mosi carries 0x02,0x00,0x00,0x44,0xA5.
  - 40 sclk rising edges.
  - request_done at edge 82.
- 2-byte read: miso returns 0x34,0x12 -> fetched_value = 0x00003412; done at edge 98.
- Handshake: hold start_request 10 cycles after done.
  - request_done stays 1.
  - Dropping start_request returns request_done to 0 and the engine to IDLE on the next edge.
  - A new start then launches the next transfer.
- rst=1 at bit 20 of a read:
  - Next edge gives cs1=cs2=1, sclk=0, mosi=0, request_done=0, fetched_value=0.
  - A following request runs normally.
- num_bytes=3: no chip select asserts, sclk stays 0, request_done is high 2 edges after start.
